cabac_seq_ctrl: RTL and testbench
=================================

CABAC_SEQ_CTRL -- requirements
Module: cabac_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_VPS, default 12'h000, register address of CABAC VPS word 0.
REQ-002 SHALL have parameter ADDR_SPS0, default 12'h004; ADDR_SPS1, default 12'h008; ADDR_PPS0, default 12'h00C; ADDR_SH0, default 12'h010; ADDR_START, default 12'h020.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000000, maximum cycles between CTU completions before the timeout error.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high.
REQ-006 cmd_start  input  1  one-cycle pulse requesting one slice decode; ignored unless idle.
REQ-007 cfg_vps, cfg_sps0, cfg_sps1, cfg_pps0, cfg_sh0  input  32 each  register words; sampled on the cycle cmd_start is accepted.
REQ-008 req_vld / req_wr / req_addr / req_wdata  output  1/1/12/32  register-bus request toward the CABAC.
REQ-009 resp_vld / resp_rdata  input  1/32  register-bus response; one response per request.
REQ-010 ctu_done_intr, done_intr, error_intr  input  1 each  CABAC completion and error pulses.
REQ-011 busy  output  1  high from acceptance until done_o or err_o.
REQ-012 done_o / err_o  output  1 each  one-cycle completion and failure pulses.
REQ-013 err_code  output  2  0 none, 1 CABAC error, 2 timeout, 3 readback mismatch; held until the next accepted cmd_start.
REQ-014 ctu_cnt  output  16  CTUs completed in the current slice.

Function
REQ-015 FSM states SHALL be IDLE, CFG_WR, CFG_RD, START_WR, RUN, FIN.
REQ-016 On cmd_start in IDLE, the block SHALL latch the five cfg words, clear ctu_cnt and err_code, set busy, and enter CFG_WR on the next cycle.
REQ-017 CFG_WR SHALL issue five writes in order VPS, SPS0, SPS1, PPS0, SH0 using an internal index 0..4.
REQ-018 Each write SHALL assert req_vld with req_wr=1 for exactly one cycle and then wait for resp_vld; at most one request SHALL be outstanding.
REQ-019 After a response, the next request SHALL be issued in the following cycle, so the minimum spacing is 2 cycles per access.
REQ-020 After the fifth write response, the FSM SHALL go to CFG_RD when readback is compiled in, otherwise to START_WR.
REQ-021 START_WR SHALL write 32'h1 to ADDR_START, wait for resp_vld, then enter RUN.
REQ-022 In RUN, each ctu_done_intr SHALL increment ctu_cnt, saturating at 16'hFFFF, and reset the timeout counter.
REQ-023 In RUN, the timeout counter SHALL increment every cycle; on reaching TIMEOUT_CYC the block SHALL set err_code=2.
REQ-024 In RUN, done_intr SHALL lead to completion and error_intr SHALL set err_code=1; if both occur in the same cycle, error takes priority.
REQ-025 If ctu_done_intr coincides with done_intr, the CTU SHALL still be counted.
REQ-026 Completion or any error SHALL move the FSM to FIN. FIN SHALL pulse done_o if err_code==0, otherwise err_o, then return to IDLE and drop busy in the same cycle.
REQ-027 Interrupt inputs outside RUN SHALL be ignored, and cmd_start while busy SHALL be dropped.
REQ-028 resp_vld arriving with no outstanding request SHALL be ignored.

Reset
REQ-029 Reset SHALL force IDLE and set req_vld, req_wr, busy, done_o, err_o, err_code, ctu_cnt and the timeout counter to 0.
REQ-030 Reset SHALL abort any transfer in flight, and a late resp_vld after reset SHALL be ignored per REQ-028.

Configuration
REQ-031 Macro CABAC_SEQ_READBACK_EN defined: CFG_RD SHALL read the five registers in write order and compare each resp_rdata to the latched word.
REQ-032 On the first mismatch, the block SHALL set err_code=3 and go to FIN without issuing START.
REQ-033 Macro undefined: the CFG_RD state and comparators SHALL be absent, and err_code value 3 SHALL never occur.

Verification
REQ-034 Slice run: cmd_start with cfg_sps0=32'h033F_1DF0 and response latency 1 -> writes in the order 000, 004, 008, 00C, 010, 020 with matching data; 390 ctu_done pulses and then done_intr -> ctu_cnt=390 and a single done_o pulse.
REQ-035 Error: error_intr after 5 CTUs -> err_o pulse, err_code=1, ctu_cnt=5, busy low the cycle after.
REQ-036 Timeout: TIMEOUT_CYC=100 and no ctu_done after START -> err_o exactly 100 cycles after RUN entry plus FIN, err_code=2.
REQ-037 Readback (macro on): SPS1 read returns 32'hDEAD_BEEF -> err_code=3, no ADDR_START write; with the macro off, no reads are issued.
REQ-038 Stress: cmd_start while busy is ignored; reset asserted mid-CFG_WR followed by a late resp_vld -> IDLE, no request issued; ctu_done and done_intr in the same cycle -> counted, then done_o.

Source files
------------

// File: rtl/cabac_seq_ctrl.sv
// cabac_seq_ctrl: sequences one CABAC slice decode. It writes the VPS/SPS0/SPS1/PPS0/SH0
// words over a single-outstanding register bus and then writes START. While the slice runs
// it counts CTU completions, watches for a CTU timeout, and reports done or error.
// Optional build macro CABAC_SEQ_READBACK_EN: read back the five words after writing them
// and abort with err_code 3 on the first mismatch.
module cabac_seq_ctrl #(
   parameter logic [11:0] ADDR_VPS    = 12'h000,
   parameter logic [11:0] ADDR_SPS0   = 12'h004,
   parameter logic [11:0] ADDR_SPS1   = 12'h008,
   parameter logic [11:0] ADDR_PPS0   = 12'h00C,
   parameter logic [11:0] ADDR_SH0    = 12'h010,
   parameter logic [11:0] ADDR_START  = 12'h020,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_start,
   input  logic [31:0] cfg_vps,
   input  logic [31:0] cfg_sps0,
   input  logic [31:0] cfg_sps1,
   input  logic [31:0] cfg_pps0,
   input  logic [31:0] cfg_sh0,
   output logic        req_vld,
   output logic        req_wr,
   output logic [11:0] req_addr,
   output logic [31:0] req_wdata,
   input  logic        resp_vld,
   input  logic [31:0] resp_rdata,
   input  logic        ctu_done_intr,
   input  logic        done_intr,
   input  logic        error_intr,
   output logic        busy,
   output logic        done_o,
   output logic        err_o,
   output logic [1:0]  err_code,
   output logic [15:0] ctu_cnt
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CFG_WR   = 3'd1,
`ifdef CABAC_SEQ_READBACK_EN
      S_CFG_RD   = 3'd2,
`endif
      S_START_WR = 3'd3,
      S_RUN      = 3'd4,
      S_FIN      = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        idx_q, idx_d;        // which config word is being accessed (0..4)
   logic              pend_q, pend_d;      // a request is outstanding, waiting for resp_vld
   logic [15:0]       ctu_cnt_q, ctu_cnt_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [31:0]       cfg_q [5];

   logic              accept;
   logic              resp_ok;
   logic              last_idx;
   logic              tmo_hit;
   logic [31:0]       cur_word;
   logic [11:0]       cur_addr;

   assign accept   = (state_q == S_IDLE) && cmd_start;
   // A response only counts while a request is outstanding; stray ones are dropped.
   assign resp_ok  = pend_q && resp_vld;
   assign last_idx = (idx_q == 3'd4);
   // A CTU completion in the same cycle rescues the slice from the timeout.
   assign tmo_hit  = (state_q == S_RUN) && !ctu_done_intr && (tmo_q == TMO_LAST);

`ifdef CABAC_SEQ_READBACK_EN
   logic rb_bad;
   assign rb_bad = resp_ok && (resp_rdata != cur_word);
`else
   logic unused_rdata;
   assign unused_rdata = ^resp_rdata;
`endif

   // Select the latched word and its register address for the current index.
   always_comb begin
      cur_word = cfg_q[4];
      cur_addr = ADDR_SH0;
      case (idx_q)
         3'd0: begin cur_word = cfg_q[0]; cur_addr = ADDR_VPS;  end
         3'd1: begin cur_word = cfg_q[1]; cur_addr = ADDR_SPS0; end
         3'd2: begin cur_word = cfg_q[2]; cur_addr = ADDR_SPS1; end
         3'd3: begin cur_word = cfg_q[3]; cur_addr = ADDR_PPS0; end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (accept) state_d = S_CFG_WR;
         S_CFG_WR:   if (resp_ok && last_idx) begin
`ifdef CABAC_SEQ_READBACK_EN
                        state_d = S_CFG_RD;
`else
                        state_d = S_START_WR;
`endif
                     end
`ifdef CABAC_SEQ_READBACK_EN
         S_CFG_RD:   if (rb_bad)                   state_d = S_FIN;
                     else if (resp_ok && last_idx) state_d = S_START_WR;
`endif
         S_START_WR: if (resp_ok) state_d = S_RUN;
         S_RUN:      if (error_intr || tmo_hit || done_intr) state_d = S_FIN;
         S_FIN:      state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output decode: a request is presented for one cycle whenever nothing is outstanding.
   always_comb begin
      req_vld   = 1'b0;
      req_wr    = 1'b0;
      req_addr  = cur_addr;
      req_wdata = 32'h0;
      done_o    = 1'b0;
      err_o     = 1'b0;
      busy      = (state_q != S_IDLE);
      case (state_q)
         S_CFG_WR: begin
            req_vld   = !pend_q;
            req_wr    = !pend_q;
            req_wdata = cur_word;
         end
`ifdef CABAC_SEQ_READBACK_EN
         S_CFG_RD: req_vld = !pend_q;
`endif
         S_START_WR: begin
            req_vld   = !pend_q;
            req_wr    = !pend_q;
            req_addr  = ADDR_START;
            req_wdata = 32'h1;
         end
         S_FIN: begin
            done_o = (err_code_q == 2'd0);
            err_o  = (err_code_q != 2'd0);
         end
         default: ;
      endcase
   end

   // Datapath next values: bus handshake tracking, CTU counting, timeout and error code.
   always_comb begin
      idx_d      = idx_q;
      pend_d     = pend_q;
      ctu_cnt_d  = ctu_cnt_q;
      err_code_d = err_code_q;
      tmo_d      = tmo_q;
      if (req_vld) pend_d = 1'b1;
      if (resp_ok) pend_d = 1'b0;
      case (state_q)
         S_IDLE: if (cmd_start) begin
            idx_d      = 3'd0;
            pend_d     = 1'b0;
            ctu_cnt_d  = 16'h0;
            err_code_d = 2'd0;
            tmo_d      = '0;
         end
         S_CFG_WR: if (resp_ok) idx_d = last_idx ? 3'd0 : idx_q + 3'd1;
`ifdef CABAC_SEQ_READBACK_EN
         S_CFG_RD: if (resp_ok) begin
            idx_d = last_idx ? 3'd0 : idx_q + 3'd1;
            if (rb_bad) err_code_d = 2'd3;
         end
`endif
         S_START_WR: if (resp_ok) tmo_d = '0;
         S_RUN: begin
            if (ctu_done_intr) begin
               ctu_cnt_d = (ctu_cnt_q == 16'hFFFF) ? ctu_cnt_q : ctu_cnt_q + 16'd1;
               tmo_d     = '0;
            end else begin
               tmo_d     = tmo_q + TMO_W'(1);
            end
            if (error_intr)   err_code_d = 2'd1;
            else if (tmo_hit) err_code_d = 2'd2;
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         idx_q      <= 3'd0;
         pend_q     <= 1'b0;
         ctu_cnt_q  <= 16'h0;
         err_code_q <= 2'd0;
         tmo_q      <= '0;
      end else begin
         idx_q      <= idx_d;
         pend_q     <= pend_d;
         ctu_cnt_q  <= ctu_cnt_d;
         err_code_q <= err_code_d;
         tmo_q      <= tmo_d;
      end
   end

   // Capture the five configuration words on acceptance; held for the whole slice.
   always_ff @(posedge clk) begin
      if (accept) begin
         cfg_q[0] <= cfg_vps;
         cfg_q[1] <= cfg_sps0;
         cfg_q[2] <= cfg_sps1;
         cfg_q[3] <= cfg_pps0;
         cfg_q[4] <= cfg_sh0;
      end
   end

   assign err_code = err_code_q;
   assign ctu_cnt  = ctu_cnt_q;

endmodule

// File: tb/tb_cabac_seq_ctrl.sv
// Testbench for cabac_seq_ctrl: directed slice scenarios plus randomized slices, checked
// against a transaction-level model of the expected register traffic and slice outcome.
module tb_cabac_seq_ctrl;

   localparam int TMO = 100;

   logic        clk;
   logic        rst_n;
   logic        cmd_start;
   logic [31:0] cfg_vps, cfg_sps0, cfg_sps1, cfg_pps0, cfg_sh0;
   logic        req_vld, req_wr;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_vld;
   logic [31:0] resp_rdata;
   logic        ctu_done_intr, done_intr, error_intr;
   logic        busy, done_o, err_o;
   logic [1:0]  err_code;
   logic [15:0] ctu_cnt;

   cabac_seq_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start),
      .cfg_vps(cfg_vps), .cfg_sps0(cfg_sps0), .cfg_sps1(cfg_sps1),
      .cfg_pps0(cfg_pps0), .cfg_sh0(cfg_sh0),
      .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_vld(resp_vld), .resp_rdata(resp_rdata),
      .ctu_done_intr(ctu_done_intr), .done_intr(done_intr), .error_intr(error_intr),
      .busy(busy), .done_o(done_o), .err_o(err_o), .err_code(err_code), .ctu_cnt(ctu_cnt)
   );

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      int          cyc;
   } txn_t;

   txn_t        log_q[$];
   logic [31:0] mirror [logic [11:0]];
   logic [11:0] addr_tab [5];
   int          lat = 1;
   logic [11:0] corrupt = 12'hFFF;
   int          cyc = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          n_chk = 0;
   int          n_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Register-bus slave: logs every request, answers after 'lat' cycles.
   initial begin : responder
      int          cd;
      logic [31:0] rd;
      cd = 0;
      rd = 32'h0;
      resp_vld = 1'b0;
      resp_rdata = 32'h0;
      forever begin
         @(negedge clk);
         resp_vld = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               resp_vld = 1'b1;
               resp_rdata = rd;
            end
         end
         if (req_vld) begin
            txn_t t;
            t.wr = req_wr;
            t.addr = req_addr;
            t.data = req_wdata;
            t.cyc = cyc;
            log_q.push_back(t);
            if (req_wr) begin
               mirror[req_addr] = req_wdata;
               rd = 32'h0;
            end else if (req_addr == corrupt) begin
               rd = 32'hDEAD_BEEF;
            end else begin
               rd = mirror.exists(req_addr) ? mirror[req_addr] : 32'h0;
            end
            cd = lat;
         end
      end
   end

   // Pulse counter, used to prove exactly one done/err pulse per slice.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (done_o) done_cnt++;
         if (err_o)  err_cnt++;
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int find_start(input int base);
      for (int i = base; i < log_q.size(); i++)
         if (log_q[i].wr && log_q[i].addr == 12'h020) return i;
      return -1;
   endfunction

   // kind: 0 done, 1 error, 2 ctu_done coincident with done, 3 timeout.
   task automatic run_slice(input int kind, input int nctu, input int lat_i, input int maxgap,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3, input logic [31:0] w4,
                            input logic [11:0] bad, input bit poke);
      logic [31:0] w [5];
      txn_t        exp_q[$];
      txn_t        e;
      int          base, dbase, ebase, si, n, last_ctu, run_cyc, exp_ctu, exp_code, nlog;
      bit          bad_hit;
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
      lat = lat_i;
      corrupt = bad;
      base = log_q.size();
      dbase = done_cnt;
      ebase = err_cnt;
      run_cyc = 0;
      last_ctu = 0;

      // Expected register traffic and outcome.
      bad_hit = 1'b0;
      for (int i = 0; i < 5; i++) begin
         e.wr = 1'b1; e.addr = addr_tab[i]; e.data = w[i]; e.cyc = 0;
         exp_q.push_back(e);
      end
`ifdef CABAC_SEQ_READBACK_EN
      for (int i = 0; i < 5 && !bad_hit; i++) begin
         e.wr = 1'b0; e.addr = addr_tab[i]; e.data = 32'h0; e.cyc = 0;
         exp_q.push_back(e);
         if (addr_tab[i] == bad && w[i] != 32'hDEAD_BEEF) bad_hit = 1'b1;
      end
`endif
      if (!bad_hit) begin
         e.wr = 1'b1; e.addr = 12'h020; e.data = 32'h1; e.cyc = 0;
         exp_q.push_back(e);
      end
      exp_code = bad_hit ? 3 : (kind == 1) ? 1 : (kind == 3) ? 2 : 0;
      exp_ctu  = bad_hit ? 0 : (kind == 2) ? nctu + 1 : nctu;

      @(negedge clk);
      cfg_vps = w[0]; cfg_sps0 = w[1]; cfg_sps1 = w[2]; cfg_pps0 = w[3]; cfg_sh0 = w[4];
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("busy_on_accept", busy, 1);
      chk("ctu_cleared", ctu_cnt, 0);
      chk("code_cleared", err_code, 0);
      if (poke) begin
         // Outside RUN: interrupts and a second cmd_start with different words are ignored.
         cfg_vps = ~w[0]; cfg_sps0 = ~w[1]; cfg_sps1 = ~w[2]; cfg_pps0 = ~w[3]; cfg_sh0 = ~w[4];
         cmd_start = 1'b1; ctu_done_intr = 1'b1; done_intr = 1'b1; error_intr = 1'b1;
         @(negedge clk);
         cmd_start = 1'b0; ctu_done_intr = 1'b0; done_intr = 1'b0; error_intr = 1'b0;
      end

      n = 0;
      forever begin
         si = find_start(base);
         if (si >= 0 || done_o || err_o || n >= 400) break;
         @(negedge clk);
         n++;
      end

      if (si >= 0) begin
         run_cyc = log_q[si].cyc + lat_i + 1;
         while (cyc < run_cyc) @(negedge clk);
         for (int i = 0; i < nctu; i++) begin
            ctu_done_intr = 1'b1;
            last_ctu = cyc;
            @(negedge clk);
            ctu_done_intr = 1'b0;
            if (poke && i == nctu / 2) begin
               cmd_start = 1'b1;
               @(negedge clk);
               cmd_start = 1'b0;
            end
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
         end
         case (kind)
            0: done_intr = 1'b1;
            1: begin error_intr = 1'b1; done_intr = 1'($urandom_range(0, 1)); end
            2: begin ctu_done_intr = 1'b1; done_intr = 1'b1; end
            default: ;
         endcase
         if (kind != 3) begin
            @(negedge clk);
            ctu_done_intr = 1'b0; done_intr = 1'b0; error_intr = 1'b0;
         end
      end

      n = 0;
      while (!(done_o || err_o) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!(done_o || err_o)) begin
         chk("pulse_seen", 0, 1);
      end else begin
         chk("done_o", done_o, exp_code == 0);
         chk("err_o", err_o, exp_code != 0);
         chk("err_code", err_code, exp_code);
         chk("ctu_cnt", ctu_cnt, exp_ctu);
         chk("busy_in_fin", busy, 1);
         if (kind == 3 && !bad_hit)
            chk("tmo_cycle", cyc - ((nctu == 0) ? run_cyc : last_ctu + 1), TMO);
         @(negedge clk);
         chk("busy_after", busy, 0);
         @(negedge clk);
         @(negedge clk);
         chk("code_held", err_code, exp_code);
         chk("done_pulses", done_cnt - dbase, exp_code == 0);
         chk("err_pulses", err_cnt - ebase, exp_code != 0);
      end

      nlog = log_q.size() - base;
      chk("req_count", nlog, exp_q.size());
      for (int i = 0; i < nlog && i < exp_q.size(); i++) begin
         $display("  req %0d: %s addr=%03h data=%08h cyc=%0d", i,
                  log_q[base+i].wr ? "WR" : "RD", log_q[base+i].addr, log_q[base+i].data,
                  log_q[base+i].cyc);
         chk("req_wr", log_q[base+i].wr, exp_q[i].wr);
         chk("req_addr", log_q[base+i].addr, exp_q[i].addr);
         if (exp_q[i].wr) chk("req_wdata", log_q[base+i].data, exp_q[i].data);
         if (i > 0) chk("req_gap", log_q[base+i].cyc - log_q[base+i-1].cyc, lat_i + 1);
      end
      $display("slice kind=%0d ctus=%0d lat=%0d bad=%03h -> err_code=%0d ctu_cnt=%0d",
               kind, nctu, lat_i, bad, err_code, ctu_cnt);
   endtask

   task automatic reset_mid_cfg();
      int base, n, sz;
      bit bad_req;
      lat = 3;
      corrupt = 12'hFFF;
      base = log_q.size();
      @(negedge clk);
      cfg_vps = $urandom; cfg_sps0 = $urandom; cfg_sps1 = $urandom;
      cfg_pps0 = $urandom; cfg_sh0 = $urandom;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      n = 0;
      while (log_q.size() < base + 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reached_cfg", log_q.size() >= base + 2, 1);
      rst_n = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_req_vld", req_vld, 0);
      @(negedge clk);
      rst_n = 1'b0;
      sz = log_q.size();
      bad_req = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (req_vld || busy || done_o || err_o) bad_req = 1'b1;
      end
      chk("rst_quiet", bad_req, 0);
      chk("rst_no_new_req", log_q.size() - sz, 0);
      chk("rst_ctu_cnt", ctu_cnt, 0);
      chk("rst_err_code", err_code, 0);
      $display("reset mid-config: requests before reset=%0d, after=%0d",
               sz - base, log_q.size() - sz);
   endtask

   initial begin : main
      logic [11:0] bad;
      addr_tab[0] = 12'h000; addr_tab[1] = 12'h004; addr_tab[2] = 12'h008;
      addr_tab[3] = 12'h00C; addr_tab[4] = 12'h010;
      rst_n = 1'b1;
      cmd_start = 1'b0;
      cfg_vps = 32'h0; cfg_sps0 = 32'h0; cfg_sps1 = 32'h0; cfg_pps0 = 32'h0; cfg_sh0 = 32'h0;
      ctu_done_intr = 1'b0; done_intr = 1'b0; error_intr = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_req_vld", req_vld, 0);
      chk("reset_req_wr", req_wr, 0);
      chk("reset_done_o", done_o, 0);
      chk("reset_err_o", err_o, 0);
      chk("reset_err_code", err_code, 0);
      chk("reset_ctu_cnt", ctu_cnt, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      run_slice(0, 390, 1, 0, 32'h1111_0000, 32'h033F_1DF0, 32'h2222_0000, 32'h3333_0000,
                32'h4444_0000, 12'hFFF, 1'b0);
      run_slice(1, 5, 1, 2, $urandom, $urandom, $urandom, $urandom, $urandom, 12'hFFF, 1'b0);
      run_slice(3, 0, 2, 0, $urandom, $urandom, $urandom, $urandom, $urandom, 12'hFFF, 1'b0);
      run_slice(0, 3, 1, 1, $urandom, $urandom, 32'h0123_4567, $urandom, $urandom, 12'h008, 1'b0);
      run_slice(2, 4, 2, 2, $urandom, $urandom, $urandom, $urandom, $urandom, 12'hFFF, 1'b1);
      reset_mid_cfg();
      run_slice(0, 2, 1, 1, $urandom, $urandom, $urandom, $urandom, $urandom, 12'hFFF, 1'b0);

      for (int k = 0; k < 14; k++) begin
         bad = ($urandom_range(0, 3) == 0) ? addr_tab[$urandom_range(0, 4)] : 12'hFFF;
         run_slice($urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(1, 3), 3,
                   $urandom, $urandom, $urandom, $urandom, $urandom, bad,
                   1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
